// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory access unit: funct3 size codes, FSM
// state encoding and an access-size decode helper.
package riscv_mem_pkg;

  // funct3 encodings of the load/store width field
  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StDone
  } mau_state_e;

  typedef enum logic [1:0] {
    SizeB,
    SizeH,
    SizeW
  } mem_size_e;

  // Width comes from funct3[1:0]; funct3[2] only selects zero extension.
  // Reserved codes fall through to word size.
  function automatic mem_size_e mem_size(input logic [1:0] op_lo);
    case (op_lo)
      2'b00:   return SizeB;
      2'b01:   return SizeH;
      default: return SizeW;
    endcase
  endfunction

endpackage

// File: rtl/load_data_align.sv
// Picks the addressed byte/halfword out of a 32-bit read word and
// sign- or zero-extends it according to funct3.
module load_data_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  mem_op_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sext;

  // Lane select followed by extension
  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (addr_lo_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    sext     = ~mem_op_i[2];
    case (mem_size(mem_op_i[1:0]))
      SizeB:   data_o = {{24{sext & byte_sel[7]}}, byte_sel};
      SizeH:   data_o = {{16{sext & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: accepts one op at a time, runs a single bus
// transaction for loads/stores and presents a one-cycle writeback.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses trap with
// Misalign_o instead of being silently force-aligned.
module mem_access_unit
  import riscv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Valid_i,
  output logic        Ready_o,
  input  logic [31:0] ALU_Result_i,
  input  logic [31:0] Store_Data_i,
  input  logic        Mem_Read_i,
  input  logic        Mem_Write_i,
  input  logic [2:0]  Mem_Op_i,
  output logic        Bus_Req_o,
  output logic        Bus_We_o,
  output logic [31:0] Bus_Addr_o,
  output logic [31:0] Bus_WData_o,
  output logic [3:0]  Bus_BE_o,
  input  logic        Bus_Ack_i,
  input  logic [31:0] Bus_RData_i,
  output logic        WB_Valid_o,
  output logic        WB_We_o,
  output logic [31:0] WB_Data_o,
  output logic        Misalign_o
);

  mau_state_e  state_q;
  logic [2:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic        we_q;

  logic        is_mem;
  logic        misaligned;
  logic        trap;
  logic [31:0] addr_eff;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;

  assign Ready_o = (state_q == StIdle);

  // Decode the incoming op: byte enables, store replication, alignment
  always_comb begin
    is_mem     = Mem_Read_i | Mem_Write_i;
    addr_eff   = ALU_Result_i;
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata      = Store_Data_i;
    case (mem_size(Mem_Op_i[1:0]))
      SizeB: begin
        be    = 4'b0001 << ALU_Result_i[1:0];
        wdata = {4{Store_Data_i[7:0]}};
      end
      SizeH: begin
        misaligned  = ALU_Result_i[0];
        addr_eff[0] = 1'b0;
        be          = ALU_Result_i[1] ? 4'b1100 : 4'b0011;
        wdata       = {2{Store_Data_i[15:0]}};
      end
      default: begin
        misaligned    = |ALU_Result_i[1:0];
        addr_eff[1:0] = 2'b00;
        be            = 4'b1111;
      end
    endcase
`ifdef MISALIGN_TRAP_EN
    trap = is_mem & misaligned;
`else
    trap = 1'b0;
`endif
  end

  load_data_align u_load_data_align (
    .rdata_i   (Bus_RData_i),
    .addr_lo_i (addr_lo_q),
    .mem_op_i  (op_q),
    .data_o    (load_data)
  );

  // FSM with registered bus and writeback outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      op_q        <= 3'b000;
      addr_lo_q   <= 2'b00;
      we_q        <= 1'b0;
      Bus_Req_o   <= 1'b0;
      Bus_We_o    <= 1'b0;
      Bus_Addr_o  <= 32'h0;
      Bus_WData_o <= 32'h0;
      Bus_BE_o    <= 4'b0000;
      WB_Valid_o  <= 1'b0;
      WB_We_o     <= 1'b0;
      WB_Data_o   <= 32'h0;
      Misalign_o  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (Valid_i) begin
            op_q      <= Mem_Op_i;
            addr_lo_q <= addr_eff[1:0];
            we_q      <= Mem_Write_i;
            if (trap) begin
              state_q    <= StDone;
              WB_Valid_o <= 1'b1;
              WB_We_o    <= 1'b0;
              WB_Data_o  <= 32'h0;
              Misalign_o <= 1'b1;
            end else if (is_mem) begin
              state_q     <= StBus;
              Bus_Req_o   <= 1'b1;
              Bus_We_o    <= Mem_Write_i;
              Bus_Addr_o  <= {addr_eff[31:2], 2'b00};
              Bus_WData_o <= Mem_Write_i ? wdata : 32'h0;
              Bus_BE_o    <= be;
            end else begin
              state_q    <= StDone;
              WB_Valid_o <= 1'b1;
              WB_We_o    <= 1'b1;
              WB_Data_o  <= ALU_Result_i;
            end
          end
        end
        StBus: begin
          if (Bus_Ack_i) begin
            state_q     <= StDone;
            Bus_Req_o   <= 1'b0;
            Bus_We_o    <= 1'b0;
            Bus_Addr_o  <= 32'h0;
            Bus_WData_o <= 32'h0;
            Bus_BE_o    <= 4'b0000;
            WB_Valid_o  <= 1'b1;
            WB_We_o     <= ~we_q;
            WB_Data_o   <= we_q ? 32'h0 : load_data;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          WB_Valid_o <= 1'b0;
          WB_We_o    <= 1'b0;
          WB_Data_o  <= 32'h0;
          Misalign_o <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; expected values are hand-computed.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Valid_i;
  logic        Ready_o;
  logic [31:0] ALU_Result_i;
  logic [31:0] Store_Data_i;
  logic        Mem_Read_i;
  logic        Mem_Write_i;
  logic [2:0]  Mem_Op_i;
  logic        Bus_Req_o;
  logic        Bus_We_o;
  logic [31:0] Bus_Addr_o;
  logic [31:0] Bus_WData_o;
  logic [3:0]  Bus_BE_o;
  logic        Bus_Ack_i;
  logic [31:0] Bus_RData_i;
  logic        WB_Valid_o;
  logic        WB_We_o;
  logic [31:0] WB_Data_o;
  logic        Misalign_o;

  int tests = 0;
  int fails = 0;

  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .Valid_i      (Valid_i),
    .Ready_o      (Ready_o),
    .ALU_Result_i (ALU_Result_i),
    .Store_Data_i (Store_Data_i),
    .Mem_Read_i   (Mem_Read_i),
    .Mem_Write_i  (Mem_Write_i),
    .Mem_Op_i     (Mem_Op_i),
    .Bus_Req_o    (Bus_Req_o),
    .Bus_We_o     (Bus_We_o),
    .Bus_Addr_o   (Bus_Addr_o),
    .Bus_WData_o  (Bus_WData_o),
    .Bus_BE_o     (Bus_BE_o),
    .Bus_Ack_i    (Bus_Ack_i),
    .Bus_RData_i  (Bus_RData_i),
    .WB_Valid_o   (WB_Valid_o),
    .WB_We_o      (WB_We_o),
    .WB_Data_o    (WB_Data_o),
    .Misalign_o   (Misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single accept edge.
  task automatic issue(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] alu, input logic [31:0] sd);
    Valid_i      = 1'b1;
    Mem_Read_i   = rd;
    Mem_Write_i  = wr;
    Mem_Op_i     = op;
    ALU_Result_i = alu;
    Store_Data_i = sd;
    tick();
    Valid_i      = 1'b0;
    Mem_Read_i   = 1'b0;
    Mem_Write_i  = 1'b0;
  endtask

  // Pulse ack with read data for one edge.
  task automatic ack(input logic [31:0] rdata);
    Bus_Ack_i   = 1'b1;
    Bus_RData_i = rdata;
    tick();
    Bus_Ack_i   = 1'b0;
    Bus_RData_i = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b0;
    Valid_i      = 1'b0;
    ALU_Result_i = 32'h0;
    Store_Data_i = 32'h0;
    Mem_Read_i   = 1'b0;
    Mem_Write_i  = 1'b0;
    Mem_Op_i     = 3'b000;
    Bus_Ack_i    = 1'b0;
    Bus_RData_i  = 32'h0;
    tick();
    tick();

    // Reset state
    check("rst_ready", Ready_o, 1);
    check("rst_req", Bus_Req_o, 0);
    check("rst_addr", Bus_Addr_o, 0);
    check("rst_be", Bus_BE_o, 0);
    check("rst_wbv", WB_Valid_o, 0);
    check("rst_wbdata", WB_Data_o, 0);
    check("rst_mis", Misalign_o, 0);
    reset = 1'b1;
    tick();

    // Ack outside BUS is ignored
    Bus_Ack_i = 1'b1;
    tick();
    Bus_Ack_i = 1'b0;
    check("idle_ack_wbv", WB_Valid_o, 0);
    check("idle_ack_ready", Ready_o, 1);

    // Non-memory op
    issue(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'h0);
    check("alu_wbv", WB_Valid_o, 1);
    check("alu_wbdata", WB_Data_o, 32'h0000_1234);
    check("alu_wbwe", WB_We_o, 1);
    check("alu_req", Bus_Req_o, 0);
    check("alu_ready", Ready_o, 0);
    tick();
    check("alu_wbv_drop", WB_Valid_o, 0);
    check("alu_req2", Bus_Req_o, 0);
    check("alu_ready2", Ready_o, 1);

    // LB 0x103, ack after 3 cycles; Valid_i held high meanwhile is ignored
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
    Valid_i = 1'b1;
    ALU_Result_i = 32'h0000_0555;
    for (int i = 0; i < 3; i++) begin
      check("lb_req", Bus_Req_o, 1);
      check("lb_we", Bus_We_o, 0);
      check("lb_addr", Bus_Addr_o, 32'h0000_0100);
      check("lb_be", Bus_BE_o, 4'b1000);
      check("lb_wbv_wait", WB_Valid_o, 0);
      tick();
    end
    Valid_i = 1'b0;
    ack(32'h80FF_FFFF);
    check("lb_wbv", WB_Valid_o, 1);
    check("lb_wbdata", WB_Data_o, 32'hFFFF_FF80);
    check("lb_wbwe", WB_We_o, 1);
    check("lb_req_drop", Bus_Req_o, 0);
    tick();
    check("lb_wbv_drop", WB_Valid_o, 0);
    check("lb_ready", Ready_o, 1);

    // LHU 0x202
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0);
    check("lhu_addr", Bus_Addr_o, 32'h0000_0200);
    check("lhu_be", Bus_BE_o, 4'b1100);
    ack(32'h8001_0000);
    check("lhu_wbdata", WB_Data_o, 32'h0000_8001);
    tick();

    // LH 0x202 sign-extends the same halfword
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0);
    ack(32'h8001_0000);
    check("lh_wbdata", WB_Data_o, 32'hFFFF_8001);
    tick();

    // LBU 0x001
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0001, 32'h0);
    check("lbu_be", Bus_BE_o, 4'b0010);
    ack(32'h0000_A500);
    check("lbu_wbdata", WB_Data_o, 32'h0000_00A5);
    tick();

    // SH 0x002
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'hAAAA_BEEF);
    check("sh_wdata", Bus_WData_o, 32'hBEEF_BEEF);
    check("sh_be", Bus_BE_o, 4'b1100);
    check("sh_we", Bus_We_o, 1);
    check("sh_addr", Bus_Addr_o, 32'h0000_0000);
    ack(32'h0);
    check("sh_wbv", WB_Valid_o, 1);
    check("sh_wbwe", WB_We_o, 0);
    tick();

    // SB with read and write both set: write wins
    issue(1'b1, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_5678);
    check("sb_we", Bus_We_o, 1);
    check("sb_wdata", Bus_WData_o, 32'h7878_7878);
    check("sb_be", Bus_BE_o, 4'b0010);
    ack(32'h0);
    check("sb_wbwe", WB_We_o, 0);
    tick();

    // SW 0x004
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'hDEAD_BEEF);
    check("sw_addr", Bus_Addr_o, 32'h0000_0004);
    check("sw_wdata", Bus_WData_o, 32'hDEAD_BEEF);
    check("sw_be", Bus_BE_o, 4'b1111);
    ack(32'h0);
    tick();

    // LW at misaligned 0x101
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0);
`ifdef MISALIGN_TRAP_EN
    check("lwmis_mis", Misalign_o, 1);
    check("lwmis_req", Bus_Req_o, 0);
    check("lwmis_wbv", WB_Valid_o, 1);
    check("lwmis_wbwe", WB_We_o, 0);
    tick();
    check("lwmis_mis_drop", Misalign_o, 0);
    check("lwmis_ready", Ready_o, 1);
`else
    check("lwmis_mis", Misalign_o, 0);
    check("lwmis_req", Bus_Req_o, 1);
    check("lwmis_addr", Bus_Addr_o, 32'h0000_0100);
    check("lwmis_be", Bus_BE_o, 4'b1111);
    ack(32'h1122_3344);
    check("lwmis_wbdata", WB_Data_o, 32'h1122_3344);
    check("lwmis_mis2", Misalign_o, 0);
    tick();
`endif

    // Reset during BUS, then a late ack
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
    check("rb_req", Bus_Req_o, 1);
    reset = 1'b0;
    tick();
    check("rb_req_drop", Bus_Req_o, 0);
    check("rb_ready", Ready_o, 1);
    reset = 1'b1;
    ack(32'hCAFE_F00D);
    check("rb_wbv", WB_Valid_o, 0);
    check("rb_ready2", Ready_o, 1);
    tick();
    check("rb_wbv2", WB_Valid_o, 0);
    check("rb_req2", Bus_Req_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have port Valid_i  input  1  upstream op valid.
REQ-004 SHALL have port Ready_o  output  1  unit can accept an op.
REQ-005 SHALL have port ALU_Result_i  input  32  byte address (memory ops) or result to pass through.
REQ-006 SHALL have port Store_Data_i  input  32  rs2 value for stores.
REQ-007 SHALL have ports Mem_Read_i, Mem_Write_i  input  1 each  load/store select.
REQ-008 SHALL have port Mem_Op_i  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have ports Bus_Req_o 1, Bus_We_o 1, Bus_Addr_o 32, Bus_WData_o 32, Bus_BE_o 4 (outputs), and Bus_Ack_i 1, Bus_RData_i 32 (inputs).
REQ-010 SHALL have ports WB_Valid_o 1, WB_We_o 1, WB_Data_o 32, Misalign_o 1 (outputs).

Function
REQ-011 SHALL implement states IDLE, BUS, DONE; Ready_o = 1 only in IDLE.
REQ-012 SHALL accept and register all inputs when Valid_i and Ready_o are both 1.
REQ-013 SHALL go IDLE->DONE for a non-memory op; WB_Data_o = registered ALU_Result_i, WB_We_o = 1.
REQ-014 SHALL go IDLE->BUS for a memory op; Mem_Write_i has priority over Mem_Read_i when both are 1.
REQ-015 SHALL, in BUS, hold Bus_Req_o = 1 with Bus_We_o, Bus_Addr_o, Bus_WData_o and Bus_BE_o stable until Bus_Ack_i = 1; on ack, go to DONE.
REQ-016 SHALL drive Bus_Addr_o = {addr[31:2], 2'b00}, and derive Bus_BE_o from size and addr[1:0] (B: 1<<a, H: 0011 or 1100, W: 1111).
REQ-017 SHALL replicate store data: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
REQ-018 SHALL capture Bus_RData_i on the ack cycle, select the addressed byte or halfword, and extend it: sign for B/H, zero for BU/HU.
REQ-019 SHALL hold DONE for exactly one cycle with WB_Valid_o = 1, then return to IDLE.
REQ-020 SHALL set WB_We_o = 1 for loads and 0 for stores in DONE.
REQ-021 SHALL give this latency from the accept edge: non-memory op, WB_Valid_o 1 cycle later; memory op, Bus_Req_o 1 cycle later, WB_Valid_o 1 cycle after the ack edge.
REQ-022 SHALL ignore Bus_Ack_i outside BUS, and ignore Valid_i outside IDLE.
REQ-023 SHALL drive Bus_Req_o, WB_Valid_o, WB_We_o and Misalign_o to 0 outside their active states.

Reset
REQ-024 SHALL, while reset = 0 at a clock edge, enter IDLE and drive Ready_o = 1, all Bus_* outputs = 0, WB_* outputs = 0 and Misalign_o = 0.
REQ-025 SHALL, on reset during BUS, drop Bus_Req_o at that edge, abandon the transaction, and produce no WB_Valid_o.

Configuration
REQ-026 SHALL, with MISALIGN_TRAP_EN defined, treat a misaligned access as follows: no bus request, go IDLE->DONE with WB_We_o = 0 and Misalign_o = 1 for that cycle. Misaligned means H/HU/SH with addr[0] = 1, or W/SW with addr[1:0] != 0.
REQ-027 SHALL, without MISALIGN_TRAP_EN, tie Misalign_o to 0 and force the low address bits to natural alignment (H: addr[0] = 0, W: addr[1:0] = 0) before the access proceeds.

Structure
REQ-028 SHALL place the funct3 size constants and the state encoding in shared package riscv_mem_pkg.
REQ-029 SHALL implement load extraction and extension in a combinational sub-module load_data_align.

Verification
REQ-030 SHALL cover a non-memory op: ALU_Result_i = 0x0000_1234 -> WB_Valid_o one cycle later, WB_Data_o = 0x0000_1234, WB_We_o = 1, Bus_Req_o never 1.
REQ-031 SHALL cover LB: addr 0x103, RData 0x80FF_FFFF, ack delayed 3 cycles -> Bus_Addr_o = 0x100, BE = 1000, request held stable 3 cycles, WB_Data_o = 0xFFFF_FF80.
REQ-032 SHALL cover LHU: addr 0x202, RData 0x8001_0000 -> BE = 1100, WB_Data_o = 0x0000_8001.
REQ-033 SHALL cover SH: addr 0x002, Store_Data_i = 0xAAAA_BEEF -> WData = 0xBEEF_BEEF, BE = 1100, Bus_We_o = 1, WB_We_o = 0.
REQ-034 SHALL cover LW at addr 0x101: with MISALIGN_TRAP_EN, Misalign_o = 1 and no request; without it, Bus_Addr_o = 0x100 and BE = 1111.
REQ-035 SHALL cover reset asserted in BUS followed by a late Bus_Ack_i -> IDLE, no WB_Valid_o, Ready_o = 1.
